// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage LoongArch pipeline, between ID and MEM.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   ds2es_valid/bus   decoded bundle from ID:
//                     {pc, src1, src2, alu_op[18:0], rkd_value, res_from_mem, gr_we, dest, mem_we}
//   es_allowin        EX can accept a new instruction this cycle
//   ms_allowin        MEM can accept
//   es2ms_valid/bus   bundle to MEM: {pc, res_from_mem, gr_we, dest, es_result}
//   exe_rf_we, exe_dest, alu_result, es_inst_is_ld_w
//                     forwarding / load-use information back to ID
//   data_sram_*       data SRAM request (word access only)
//
// alu_op one-hot: 0-11 ALU, 12 mul.w, 13 mulh.w, 14 mulh.wu,
//                 15 div.w, 16 div.wu, 17 mod.w, 18 mod.wu.
module ex_stage #(
    parameter int DS2ES_BUS_LEN = 155,
    parameter int ES2MS_BUS_LEN = 71
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ds2es_valid,
    input  logic [DS2ES_BUS_LEN-1:0] ds2es_bus,
    output logic                     es_allowin,
    input  logic                     ms_allowin,
    output logic                     es2ms_valid,
    output logic [ES2MS_BUS_LEN-1:0] es2ms_bus,
    output logic                     exe_rf_we,
    output logic [4:0]               exe_dest,
    output logic [31:0]              alu_result,
    output logic                     es_inst_is_ld_w,
    output logic                     data_sram_en,
    output logic [3:0]               data_sram_we,
    output logic [31:0]              data_sram_addr,
    output logic [31:0]              data_sram_wdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    logic                     es_valid;
    logic                     es_ready_go;
    logic [DS2ES_BUS_LEN-1:0] ds2es_bus_r;
    logic [31:0]              es_pc;
    logic [31:0]              src1;
    logic [31:0]              src2;
    logic [18:0]              alu_op;
    logic [31:0]              rkd_value;
    logic                     res_from_mem;
    logic                     gr_we;
    logic [4:0]               dest;
    logic                     mem_we;
    logic [31:0]              es_result;
    logic [31:0]              alu_out;

    assign {es_pc, src1, src2, alu_op, rkd_value, res_from_mem, gr_we, dest, mem_we} = ds2es_bus_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid    <= 1'b0;
            ds2es_bus_r <= '0;
        end else begin
            if (es_allowin)
                es_valid <= ds2es_valid;
            if (ds2es_valid && es_allowin)
                ds2es_bus_r <= ds2es_bus;
        end
    end

    alu u_alu (
        .alu_op     (alu_op[11:0]),
        .alu_src1   (src1),
        .alu_src2   (src2),
        .alu_result (alu_out)
    );

    // Multiplier: 64 low bits of the signed product of 33-bit extended operands
    // are all that mul.w / mulh.w / mulh.wu need.
    logic               mul_sext;
    logic signed [63:0] mul_a;
    logic signed [63:0] mul_b;
    logic signed [63:0] mul_prod;
    logic [31:0]        mul_out;

    assign mul_sext = ~alu_op[14];
    assign mul_a    = {{32{mul_sext & src1[31]}}, src1};
    assign mul_b    = {{32{mul_sext & src2[31]}}, src2};
    assign mul_prod = mul_a * mul_b;
    assign mul_out  = alu_op[12] ? mul_prod[31:0] : mul_prod[63:32];

    // Divider: restoring, one quotient bit per BUSY cycle on absolute values.
    // div_rem holds {partial remainder, dividend/quotient bits}.
    div_state_t  div_state;
    logic [4:0]  div_cnt;
    logic [63:0] div_rem;
    logic [31:0] div_dsr;
    logic        div_qneg;
    logic        div_rneg;
    logic        div_dz;
    logic        is_div;
    logic        div_signed;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] step_hi;
    logic        step_ge;
    logic [31:0] step_diff;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] div_out;

    assign is_div     = |alu_op[18:15];
    assign div_signed = alu_op[15] | alu_op[17];
    assign abs1       = (div_signed && src1[31]) ? -src1 : src1;
    assign abs2       = (div_signed && src2[31]) ? -src2 : src2;
    // The shifted partial remainder needs 33 bits; once it is >= divisor the
    // difference is below 2^32, so a 32-bit subtract is exact.
    assign step_hi    = div_rem[63:31];
    assign step_ge    = step_hi >= {1'b0, div_dsr};
    assign step_diff  = step_hi[31:0] - div_dsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_state <= IDLE;
            div_cnt   <= 5'd0;
            div_rem   <= '0;
            div_dsr   <= '0;
            div_qneg  <= 1'b0;
            div_rneg  <= 1'b0;
            div_dz    <= 1'b0;
        end else begin
            case (div_state)
                IDLE: if (es_valid && is_div) begin
                    div_state <= BUSY;
                    div_cnt   <= 5'd0;
                    div_rem   <= {32'd0, abs1};
                    div_dsr   <= abs2;
                    div_qneg  <= div_signed & (src1[31] ^ src2[31]);
                    div_rneg  <= div_signed & src1[31];
                    div_dz    <= src2 == 32'd0;
                end
                BUSY: begin
                    div_rem <= {step_ge ? step_diff : step_hi[31:0], div_rem[30:0], step_ge};
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31)
                        div_state <= DONE;
                end
                DONE: if (es_allowin)
                    div_state <= IDLE;
                default: div_state <= IDLE;
            endcase
        end
    end

    // With a zero divisor the restoring loop already leaves the dividend in the
    // remainder; only the quotient needs forcing, since sign fix-up would spoil it.
    assign div_q   = div_dz ? 32'hFFFF_FFFF : (div_qneg ? -div_rem[31:0] : div_rem[31:0]);
    assign div_r   = div_rneg ? -div_rem[63:32] : div_rem[63:32];
    assign div_out = (alu_op[17] || alu_op[18]) ? div_r : div_q;

    assign es_result   = is_div ? div_out : (|alu_op[14:12]) ? mul_out : alu_out;
    assign es_ready_go = ~is_div | (div_state == DONE);
    assign es_allowin  = ~es_valid | (es_ready_go & ms_allowin);
    assign es2ms_valid = es_valid & es_ready_go;
    assign es2ms_bus   = {es_pc, res_from_mem, gr_we, dest, es_result};

    assign exe_rf_we       = es_valid & gr_we;
    assign exe_dest        = dest;
    assign alu_result      = es_result;
    assign es_inst_is_ld_w = es_valid & res_from_mem;

    assign data_sram_en    = es_valid & (res_from_mem | mem_we) & ms_allowin;
    assign data_sram_we    = {4{es_valid & mem_we & ms_allowin}};
    assign data_sram_addr  = es_result;
    assign data_sram_wdata = rkd_value;
endmodule

// alu: one-hot 12-op integer ALU.
//   alu_op[0] add, [1] sub, [2] slt, [3] sltu, [4] and, [5] nor,
//   [6] or, [7] xor, [8] sll, [9] srl, [10] sra, [11] lui (passes src2)
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    logic        use_sub;
    logic [31:0] adder_b;
    logic [31:0] adder_sum;
    logic        adder_cout;
    logic        slt_res;
    logic        sltu_res;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;

    // sub, slt and sltu all compute src1 + ~src2 + 1.
    assign use_sub = alu_op[1] | alu_op[2] | alu_op[3];
    assign adder_b = use_sub ? ~alu_src2 : alu_src2;
    assign {adder_cout, adder_sum} = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, use_sub};

    assign slt_res  = (alu_src1[31] & ~alu_src2[31]) | (~(alu_src1[31] ^ alu_src2[31]) & adder_sum[31]);
    assign sltu_res = ~adder_cout;
    assign sll_res  = alu_src1 << alu_src2[4:0];
    assign srl_res  = alu_src1 >> alu_src2[4:0];
    assign sra_res  = $signed(alu_src1) >>> alu_src2[4:0];

    assign alu_result = ({32{alu_op[0] | alu_op[1]}} & adder_sum)
                      | ({32{alu_op[2]}}  & {31'd0, slt_res})
                      | ({32{alu_op[3]}}  & {31'd0, sltu_res})
                      | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                      | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                      | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                      | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                      | ({32{alu_op[8]}}  & sll_res)
                      | ({32{alu_op[9]}}  & srl_res)
                      | ({32{alu_op[10]}} & sra_res)
                      | ({32{alu_op[11]}} & alu_src2);
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage LoongArch pipeline, between ID and MEM.
- Latches the decoded bundle from ID and computes the result: ALU for ops 0–11, a single-cycle multiplier for ops 12–14, and an iterative 32-step divider for ops 15–18.
- Issues the data-SRAM request and returns forwarding and load-use information to ID.
- Passes `{pc, control, result}` to MEM under the valid/allowin handshake.

## Interface
- DS2ES_BUS_LEN, 155, `{pc[31:0], src1[31:0], src2[31:0], alu_op[18:0], rkd_value[31:0], res_from_mem, gr_we, dest[4:0], mem_we}`, MSB first
- ES2MS_BUS_LEN, 71, `{pc[31:0], res_from_mem, gr_we, dest[4:0], es_result[31:0]}`, MSB first
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ds2es_valid  in  1  ID holds a valid instruction
- ds2es_bus  in  DS2ES_BUS_LEN  decoded bundle
- es_allowin  out  1  EX can accept a new instruction this cycle
- ms_allowin  in  1  MEM can accept
- es2ms_valid  out  1  EX result valid toward MEM
- es2ms_bus  out  ES2MS_BUS_LEN  bundle to MEM
- exe_rf_we  out  1  `es_valid & gr_we`
- exe_dest  out  5  destination register
- alu_result  out  32  `es_result`, forwarded to ID
- es_inst_is_ld_w  out  1  `es_valid & res_from_mem`
- data_sram_en  out  1  SRAM request
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  `es_result`
- data_sram_wdata  out  32  `rkd_value`

## Operation
- Pipeline register:
  - `es_valid` is cleared on reset.
  - Otherwise, when `es_allowin` is high, `es_valid <= ds2es_valid`.
  - The bus register loads when `ds2es_valid & es_allowin`.
- Handshake:
  - `es_allowin = ~es_valid | (es_ready_go & ms_allowin)`
  - `es2ms_valid = es_valid & es_ready_go`
- `es_ready_go` is 1 for non-divide instructions. For divide instructions it is 1 only while the divider is in DONE.
- `es_result` select priority:
  - any of `alu_op[18:15]` set → divider output
  - any of `alu_op[14:12]` set → multiplier output
  - otherwise → ALU output
- ALU: the existing `alu` module, driven with `alu_op[11:0]`, src1 and src2.
- Multiplier: one 66-bit signed product of 33-bit extended operands. Operands are sign-extended for ops 12 and 13 and zero-extended for op 14.
  - op 12 (`mul.w`) returns `product[31:0]`.
  - ops 13 and 14 (`mulh.w`, `mulh.wu`) return `product[63:32]`.
  - The result is combinational within the cycle.
- Divider: restoring, one quotient bit per cycle. Dividend is src1, divisor is src2.
  - Signed ops (15 `div.w`, 17 `mod.w`) work on absolute values.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the dividend's sign.
  - Ops 15 and 16 return the quotient; ops 17 and 18 return the remainder.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend, with no exception.
- Divider FSM states:
  - IDLE → BUSY when `es_valid` and a divide op is present. On this transition it loads the absolute operands and a 64-bit working remainder, and clears the 5-bit counter.
  - BUSY: one shift-subtract step per cycle. → DONE after the step with counter = 31.
  - DONE: holds the result. → IDLE when `es_allowin` (the instruction leaves).
- SRAM request:
  - `data_sram_en = es_valid & (res_from_mem | mem_we) & ms_allowin`
  - `data_sram_we = {4{es_valid & mem_we & ms_allowin}}`
  - Only word access is supported.
- Forwarding outputs stay live during a divide stall. ID is blocked anyway because `es_allowin` = 0.

## Timing
- Reset values:
  - `es_valid` = 0, so `es2ms_valid`, `exe_rf_we`, `es_inst_is_ld_w`, `data_sram_en` and `data_sram_we` are all 0.
  - Divider is in IDLE with counter 0.
  - `es_allowin` = 1.
- Latency:
  - ALU and multiply instructions spend 1 cycle in EX when `ms_allowin` = 1.
  - Divide instructions spend 34 cycles: entry cycle (IDLE), then 32 BUSY cycles, then DONE. They leave at the end of DONE if `ms_allowin` = 1.
- Back-pressure with `ms_allowin` = 0:
  - Bus, divider result and DONE state are held; no SRAM request is issued.
  - Releasing it re-issues the request exactly once, on the cycle the instruction leaves.
- Back-to-back divides: a divide leaving DONE and a new divide entering in the same cycle means DONE → IDLE, then the next cycle IDLE → BUSY. There is no result carry-over.
- Reset during BUSY or DONE forces IDLE; the in-flight instruction is discarded.

## Test plan
- `add.w` with src1 = 5, src2 = 7, `ms_allowin` = 1 → `es2ms_valid` the cycle after acceptance, `es_result` = 12, `exe_rf_we` = 1, `exe_dest` as given.
- `div.wu` 100 / 7 → `es_allowin` = 0 for 33 cycles, then quotient 14 and `es2ms_valid` = 1 in cycle 34. `mod.wu` with the same operands → 2.
- `div.w` −7 / 2 → 0xFFFFFFFD (−3). `mod.w` −7 / 2 → 0xFFFFFFFF (−1). `div.wu` 5 / 0 → 0xFFFFFFFF. `mod.wu` 5 / 0 → 5.
- `mulh.wu` 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. `mulh.w` on the same operands → 0. `mul.w` 0x80000000 × 2 → 0.
- `st.w` held with `ms_allowin` = 0 for 3 cycles → `data_sram_en` = 0 throughout, then exactly one cycle of `data_sram_en` = 1 with `data_sram_we` = 0xF when released. `ld.w` → `es_inst_is_ld_w` = 1 and `data_sram_we` = 0.
- Reset asserted at BUSY cycle 10 → next cycle IDLE, `es_valid` = 0, `es_allowin` = 1. A following `add.w` completes normally.
